// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, the NOP encoding and the fetch-unit state type.
package core_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR   = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / flush controls.
// Ports:
//   clk, reset      rising-edge clock, async active-low reset
//   load            capture instr_in / pc4_in and mark the slot valid
//   flush           load a bubble (wins over load)
//   instr_in/pc4_in fetched word and its PC+4
//   instr/pc4/valid registered IF/ID contents
// With neither load nor flush the register holds its contents (stall).
module if_id_reg
    import core_pkg::*;
#(
    parameter int unsigned PC_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc4,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc4_q, pc4_d;
    logic               valid_q, valid_d;

    // Next-state: a bubble looks exactly like the reset contents.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the byte-address PC, the next-PC mux and the boot/run/halt FSM,
// and feeds fetched words into the IF/ID register.
// Ports:
//   clk, reset                    rising-edge clock, async active-low reset
//   stall                         hold PC and IF/ID
//   branch_taken/branch_target    EX-resolved redirect (beats jump)
//   jump/jump_target              ID-decoded redirect
//   imem_instr / imem_pc          instruction memory data / address (= PC register)
//   ifid_instr/ifid_pc4/ifid_valid  IF/ID register outputs
//   halted                        FSM is in S_HALT
//   misalign_err                  sticky misaligned-redirect flag
// Build option: IFU_MISALIGN_TRAP_EN traps misaligned redirect targets
// (flag set, PC unchanged, halt); otherwise misalign_err is tied 0.
module instruction_fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] LAST_PC  = PC_W'(20)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [PC_W-1:0]    imem_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc4,
    output logic               ifid_valid,
    output logic               halted,
    output logic               misalign_err
);

    ifu_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4_c;
    logic [PC_W-1:0] redir_target_c;
    logic            redirect_c;
    logic            load_c;
    logic            flush_c;
`ifdef IFU_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    // PC increment wraps modulo 2^PC_W by truncation.
    assign pc_plus4_c     = pc_q + PC_W'(PC_INCR);
    assign redirect_c     = branch_taken | jump;
    // EX branch is older than ID jump, so it wins.
    assign redir_target_c = branch_taken ? branch_target : jump_target;

    // Next-state / next-PC / IF/ID control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load_c  = 1'b0;
        flush_c = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (redirect_c) begin
            // Redirect overrides stall and flushes the wrong-path word.
            flush_c = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
            if (redir_target_c[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_HALT;
            end else begin
                pc_d    = redir_target_c;
                state_d = S_RUN;
            end
`else
            pc_d    = redir_target_c;
            state_d = S_RUN;
`endif
        end else begin
            case (state_q)
                S_BOOT: begin
                    // Memory is still loading; hold PC and emit a bubble.
                    flush_c = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (!stall) begin
                        load_c = 1'b1;
                        pc_d   = pc_plus4_c;
                        if (pc_q == LAST_PC) begin
                            state_d = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (!stall) begin
                        flush_c = 1'b1;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .flush    (flush_c),
        .instr_in (imem_instr),
        .pc4_in   (pc_plus4_c),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4),
        .valid    (ifid_valid)
    );

    assign imem_pc = pc_q;
    assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// stimulus, two instances (LAST_PC=20 and LAST_PC=0x3FF) against a
// cycle-level behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    typedef struct {
        int          mode;
        logic [9:0]  pc;
        logic [31:0] instr;
        logic [9:0]  pc4;
        logic        valid;
        logic        mis;
    } model_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        jump;
    logic [9:0]  jump_target;

    logic [31:0] imem0, imem1;
    logic [9:0]  pc0, pc1, pc4_0, pc4_1;
    logic [31:0] instr0, instr1;
    logic        valid0, valid1, halt0, halt1, mis0, mis1;

    logic [7:0]  mem [0:1023];

    int vectors = 0;
    int fails   = 0;

    model_t m0, m1;

    always #5 clk = ~clk;

    // Big-endian byte memory, address wraps at 1 KiB.
    assign imem0 = {mem[pc0], mem[pc0 + 10'd1], mem[pc0 + 10'd2], mem[pc0 + 10'd3]};
    assign imem1 = {mem[pc1], mem[pc1 + 10'd1], mem[pc1 + 10'd2], mem[pc1 + 10'd3]};

    instruction_fetch_unit u0 (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_instr(imem0), .imem_pc(pc0),
        .ifid_instr(instr0), .ifid_pc4(pc4_0), .ifid_valid(valid0),
        .halted(halt0), .misalign_err(mis0)
    );

    instruction_fetch_unit #(.LAST_PC(10'h3FF)) u1 (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_instr(imem1), .imem_pc(pc1),
        .ifid_instr(instr1), .ifid_pc4(pc4_1), .ifid_valid(valid1),
        .halted(halt1), .misalign_err(mis1)
    );

    function automatic logic [31:0] rd(input logic [9:0] a);
        return {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
    endfunction

    function automatic model_t reset_model();
        model_t r;
        r.mode = MODE_BOOT; r.pc = 10'd0; r.instr = 32'h0;
        r.pc4 = 10'd0; r.valid = 1'b0; r.mis = 1'b0;
        return r;
    endfunction

    // One clock of the fetch stage as described by its rules.
    function automatic model_t step(input model_t s, input logic [9:0] last,
                                    input logic rst_n, input logic st,
                                    input logic bt, input logic [9:0] btg,
                                    input logic jp, input logic [9:0] jtg);
        model_t     n;
        logic [9:0] tgt;
        n = s;
        if (!rst_n) return reset_model();
        if (bt || jp) begin
            tgt = bt ? btg : jtg;
            n.instr = 32'h0; n.pc4 = 10'd0; n.valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            if ((tgt % 4) != 0) begin
                n.mis  = 1'b1;
                n.mode = MODE_HALT;
                return n;
            end
`endif
            n.pc   = tgt;
            n.mode = MODE_RUN;
        end else if (s.mode == MODE_BOOT) begin
            n.instr = 32'h0; n.pc4 = 10'd0; n.valid = 1'b0;
            n.mode  = MODE_RUN;
        end else if (st) begin
            n = s;
        end else if (s.mode == MODE_RUN) begin
            n.instr = rd(s.pc);
            n.pc4   = s.pc + 10'd4;
            n.valid = 1'b1;
            n.pc    = s.pc + 10'd4;
            if (s.pc == last) n.mode = MODE_HALT;
        end else begin
            n.instr = 32'h0; n.pc4 = 10'd0; n.valid = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/u0.imem_pc"},  {22'd0, pc0},    {22'd0, m0.pc});
        chk({tag, "/u0.instr"},    instr0,          m0.instr);
        chk({tag, "/u0.pc4"},      {22'd0, pc4_0},  {22'd0, m0.pc4});
        chk({tag, "/u0.valid"},    {31'd0, valid0}, {31'd0, m0.valid});
        chk({tag, "/u0.halted"},   {31'd0, halt0},  {31'd0, (m0.mode == MODE_HALT)});
        chk({tag, "/u0.misalign"}, {31'd0, mis0},   {31'd0, m0.mis});
        chk({tag, "/u1.imem_pc"},  {22'd0, pc1},    {22'd0, m1.pc});
        chk({tag, "/u1.instr"},    instr1,          m1.instr);
        chk({tag, "/u1.pc4"},      {22'd0, pc4_1},  {22'd0, m1.pc4});
        chk({tag, "/u1.valid"},    {31'd0, valid1}, {31'd0, m1.valid});
        chk({tag, "/u1.halted"},   {31'd0, halt1},  {31'd0, (m1.mode == MODE_HALT)});
        chk({tag, "/u1.misalign"}, {31'd0, mis1},   {31'd0, m1.mis});
    endtask

    // Inputs are already set (at a negedge); advance one clock and check.
    task automatic cycle(input string tag);
        @(posedge clk);
        m0 = step(m0, 10'd20,  reset, stall, branch_taken, branch_target, jump, jump_target);
        m1 = step(m1, 10'h3FF, reset, stall, branch_taken, branch_target, jump, jump_target);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 10'd0; jump_target = 10'd0;
    endtask

    task automatic put_word(input logic [9:0] a, input logic [31:0] w);
        mem[a]          = w[31:24];
        mem[a + 10'd1]  = w[23:16];
        mem[a + 10'd2]  = w[15:8];
        mem[a + 10'd3]  = w[7:0];
    endtask

    // Assert reset at a negedge, verify the asynchronous clear, release after a cycle.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        m0 = reset_model();
        m1 = reset_model();
        check_all(tag);
        cycle(tag);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        put_word(10'd0,  32'h8D61000C);
        put_word(10'd4,  32'h3D020008);
        put_word(10'd20, 32'hACA40004);
        idle_inputs();
        reset = 1'b0;
        m0 = reset_model();
        m1 = reset_model();
        @(negedge clk);
        do_reset("reset");

        // Boot cycle, then first fetch.
        cycle("boot");
        chk("boot.valid", {31'd0, valid0}, 32'd0);
        chk("boot.pc",    {22'd0, pc0},    32'd0);
        cycle("fetch0");
        chk("fetch0.instr", instr0, 32'h8D61000C);
        chk("fetch0.pc4",   {22'd0, pc4_0}, 32'd4);

        // Free run to the final word and into halt.
        for (int i = 0; i < 5; i++) cycle("run");
        chk("last.instr",  instr0, 32'hACA40004);
        chk("last.halted", {31'd0, halt0}, 32'd1);
        for (int i = 0; i < 3; i++) cycle("halt");
        chk("halt.bubble", {31'd0, valid0}, 32'd0);

        // Stall for three cycles at PC=8.
        do_reset("reset2");
        cycle("boot2");
        cycle("f0");
        cycle("f4");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.pc",    {22'd0, pc0}, 32'd8);
            chk("stall.instr", instr0, 32'h3D020008);
        end
        stall = 1'b0;
        cycle("unstall");
        chk("unstall.pc", {22'd0, pc0}, 32'd12);

        // Simultaneous branch, jump and stall: branch wins, flush.
        branch_taken = 1'b1; branch_target = 10'd4;
        jump = 1'b1; jump_target = 10'd16; stall = 1'b1;
        cycle("redir");
        chk("redir.pc",    {22'd0, pc0},    32'd4);
        chk("redir.valid", {31'd0, valid0}, 32'd0);
        idle_inputs();
        cycle("redir+1");
        chk("redir+1.instr", instr0, 32'h3D020008);

        // PC wrap on the LAST_PC=0x3FF instance.
        jump = 1'b1; jump_target = 10'd1020;
        cycle("jmp1020");
        idle_inputs();
        cycle("wrap");
        chk("wrap.pc",  {22'd0, pc1},   32'd0);
        chk("wrap.pc4", {22'd0, pc4_1}, 32'd0);

        // Reset while a valid word sits in IF/ID at PC=12.
        do_reset("reset3");
        cycle("boot3");
        for (int i = 0; i < 3; i++) cycle("f");
        chk("pre.valid", {31'd0, valid0}, 32'd1);
        chk("pre.pc",    {22'd0, pc0},    32'd12);
        reset = 1'b0;
        #1;
        chk("async.valid", {31'd0, valid0}, 32'd0);
        chk("async.instr", instr0,          32'd0);
        chk("async.pc",    {22'd0, pc0},    32'd0);
        m0 = reset_model();
        m1 = reset_model();
        cycle("inreset");
        reset = 1'b1;
        cycle("boot4");

        // Misaligned jump target.
        jump = 1'b1; jump_target = 10'd6;
        cycle("mis");
`ifdef IFU_MISALIGN_TRAP_EN
        chk("mis.err",  {31'd0, mis0},  32'd1);
        chk("mis.pc",   {22'd0, pc0},   32'd0);
        chk("mis.halt", {31'd0, halt0}, 32'd1);
`else
        chk("mis.err", {31'd0, mis0}, 32'd0);
        chk("mis.pc",  {22'd0, pc0},  32'd6);
`endif
        idle_inputs();
        cycle("mis+1");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            stall        = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            jump         = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? 10'($urandom)
                                                        : 10'($urandom_range(0, 7) * 4);
            jump_target   = ($urandom_range(0, 5) == 0) ? 10'd1020
                                                        : 10'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 63) == 0) begin
                idle_inputs();
                do_reset("rand.reset");
            end else begin
                cycle("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
